// File: rtl/fir_stimulus_gen.sv
// Test-waveform source for the FIR input: zero, square, triangle or impulse trains
// with per-period shadowed configuration so every period seen downstream is clean.
module fir_stimulus_gen #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         high_cycles,
    input  logic [CNT_W-1:0]         low_cycles,
    input  logic [DATA_W-2:0]        amplitude,
    input  logic [DATA_W-2:0]        tri_step,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     phase,
    output logic                     period_start
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [1:0] MODE_ZERO     = 2'd0;
    localparam logic [1:0] MODE_SQUARE   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [1:0] MODE_IMPULSE  = 2'd3;

    logic [1:0]               state, state_nxt;
    logic [CNT_W-1:0]         count, count_nxt;
    logic signed [DATA_W-1:0] sample_nxt;
    logic                     period_start_nxt;
    logic                     load_shadow;

    logic [1:0]               sh_mode;
    logic [CNT_W-1:0]         sh_high;
    logic [CNT_W-1:0]         sh_low;
    logic [DATA_W-2:0]        sh_amp;
    logic [DATA_W-2:0]        sh_step;

    logic                     low_last, high_last;
    logic signed [DATA_W-1:0] amp_level;
    logic signed [DATA_W-1:0] low_value;
    logic signed [DATA_W-1:0] high_entry_value;
    logic signed [DATA_W-1:0] high_cont_value;

    // A programmed length of zero behaves as a one-cycle phase.
    function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] n);
        if (n == '0) begin
            return '0;
        end
        return n - CNT_W'(1);
    endfunction

    // Triangle rise: one bit of headroom so the sum can never wrap before clamping.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] prev,
        input logic [DATA_W-2:0]        step,
        input logic [DATA_W-2:0]        peak
    );
        logic signed [DATA_W:0] sum;
        logic signed [DATA_W:0] lim;
        sum = $signed({prev[DATA_W-1], prev}) + $signed({2'b00, step});
        lim = $signed({2'b00, peak});
        if (sum > lim) begin
            return $signed(lim[DATA_W-1:0]);
        end
        return $signed(sum[DATA_W-1:0]);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_sub(
        input logic signed [DATA_W-1:0] prev,
        input logic [DATA_W-2:0]        step
    );
        logic signed [DATA_W:0] diff;
        diff = $signed({prev[DATA_W-1], prev}) - $signed({2'b00, step});
        if (diff[DATA_W]) begin
            return '0;
        end
        return $signed(diff[DATA_W-1:0]);
    endfunction

    assign low_last  = (count == last_count(sh_low));
    assign high_last = (count == last_count(sh_high));
    assign amp_level = $signed({1'b0, sh_amp});

    // Sample values for the cycle being entered, all derived from shadowed config.
    always_comb begin
        low_value        = '0;
        high_entry_value = '0;
        high_cont_value  = '0;
        case (sh_mode)
            MODE_ZERO: begin
                low_value        = '0;
                high_entry_value = '0;
                high_cont_value  = '0;
            end
            MODE_SQUARE: begin
                high_entry_value = amp_level;
                high_cont_value  = amp_level;
            end
            MODE_TRIANGLE: begin
                low_value        = sat_sub(sample_out, sh_step);
                high_entry_value = sat_add(sample_out, sh_step, sh_amp);
                high_cont_value  = sat_add(sample_out, sh_step, sh_amp);
            end
            MODE_IMPULSE: begin
                high_entry_value = amp_level;
            end
            default: begin
                low_value = '0;
            end
        endcase
    end

    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        sample_nxt       = sample_out;
        period_start_nxt = 1'b0;
        load_shadow      = 1'b0;
        case (state)
            ST_IDLE: begin
                load_shadow = 1'b1;
                sample_nxt  = '0;
                count_nxt   = '0;
                if (enable) begin
                    state_nxt        = ST_LOW;
                    period_start_nxt = 1'b1;
                end
            end
            ST_LOW: begin
                if (!enable) begin
                    state_nxt  = ST_IDLE;
                    count_nxt  = '0;
                    sample_nxt = '0;
                end else if (low_last) begin
                    state_nxt  = ST_HIGH;
                    count_nxt  = '0;
                    sample_nxt = high_entry_value;
                end else begin
                    count_nxt  = count + CNT_W'(1);
                    sample_nxt = low_value;
                end
            end
            ST_HIGH: begin
                if (!enable) begin
                    state_nxt  = ST_IDLE;
                    count_nxt  = '0;
                    sample_nxt = '0;
                end else if (high_last) begin
                    state_nxt        = ST_LOW;
                    count_nxt        = '0;
                    sample_nxt       = low_value;
                    period_start_nxt = 1'b1;
                    load_shadow      = 1'b1;
                end else begin
                    count_nxt  = count + CNT_W'(1);
                    sample_nxt = high_cont_value;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                count_nxt  = '0;
                sample_nxt = '0;
            end
        endcase
    end

    // Register boundary: every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            sample_out   <= '0;
            phase        <= 1'b0;
            period_start <= 1'b0;
            sh_mode      <= '0;
            sh_high      <= '0;
            sh_low       <= '0;
            sh_amp       <= '0;
            sh_step      <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            sample_out   <= sample_nxt;
            phase        <= (state_nxt == ST_HIGH);
            period_start <= period_start_nxt;
            if (load_shadow) begin
                sh_mode <= mode;
                sh_high <= high_cycles;
                sh_low  <= low_cycles;
                sh_amp  <= amplitude;
                sh_step <= tri_step;
            end
        end
    end

endmodule
